// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic        epoch;
    logic [31:0] pc;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    StBoot,
    StRun
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction-cache request/response bus between fetch (master) and the cache (slave).
interface fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush; flush has priority over a same-cycle push.
module fetch_fifo #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order icache requests, epoch-tags them
// and buffers returned instructions for decode. Define FETCH_PERF_EN for perf counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     icache,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_killed
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         epoch_q;

  fetch_tag_t   tag_push;
  fetch_tag_t   tag_head;
  logic [1:0]   tag_count;
  logic         tag_full;
  logic         tag_empty;
  fetch_entry_t buf_push;
  fetch_entry_t buf_head;
  logic [1:0]   buf_count;
  logic         buf_empty;
  logic         unused_buf_full;
  logic [1:0]   unused_redirect_lsb;

  logic         req_fire;
  logic         resp_fire;
  logic         resp_keep;
  logic         buf_pop;
  logic [2:0]   occupancy;
  logic         has_credit;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // A same-cycle pop hands its credit straight back so decode sees one instruction per cycle.
  assign buf_pop    = f_valid & f_ready;
  assign occupancy  = {1'b0, tag_count} + {1'b0, buf_count} - {2'b00, buf_pop};
  assign has_credit = (occupancy < 3'(MAX_OUTSTANDING)) & ~tag_full;

  assign icache.req_valid = (state_q == StRun) & has_credit & ~redirect_valid;
  assign icache.req_addr  = pc_q;
  assign req_fire         = icache.req_valid & icache.req_ready;

  assign resp_fire = icache.resp_valid & ~tag_empty;
  assign resp_keep = resp_fire & (tag_head.epoch == epoch_q);

  assign tag_push = '{epoch: epoch_q, pc: pc_q};
  assign buf_push = '{pc: tag_head.pc, inst: icache.resp_data};

  assign f_valid = ~buf_empty & ~redirect_valid;
  assign f_pc    = buf_empty ? 32'h0 : buf_head.pc;
  assign f_inst  = buf_empty ? INST_NOP : buf_head.inst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      case (state_q)
        StBoot:  state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StBoot;
      endcase
      if (redirect_valid) begin
        pc_q    <= {redirect_pc[31:2], 2'b00};
        epoch_q <= ~epoch_q;
      end else if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // Tags are never flushed: wrong-path responses must still drain in order.
  fetch_fifo #(
    .Width($bits(fetch_tag_t))
  ) u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (1'b0),
    .push     (req_fire),
    .push_data(tag_push),
    .pop      (resp_fire),
    .head     (tag_head),
    .count    (tag_count),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  fetch_fifo #(
    .Width($bits(fetch_entry_t))
  ) u_out_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (redirect_valid),
    .push     (resp_keep),
    .push_data(buf_push),
    .pop      (buf_pop),
    .head     (buf_head),
    .count    (buf_count),
    .full     (unused_buf_full),
    .empty    (buf_empty)
  );

`ifdef FETCH_PERF_EN
  logic        resp_drop;
  logic [1:0]  killed_inc;
  logic [31:0] stall_q;
  logic [31:0] killed_q;

  // A same-epoch response in a redirect cycle is lost to the flush, so it counts as killed.
  assign resp_drop  = resp_fire & (~resp_keep | redirect_valid);
  assign killed_inc = (redirect_valid ? buf_count : 2'd0) + {1'b0, resp_drop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      killed_q <= '0;
    end else begin
      if (f_valid && !f_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (killed_q > (32'hFFFF_FFFF - 32'(killed_inc))) begin
        killed_q <= '1;
      end else begin
        killed_q <= killed_q + 32'(killed_inc);
      end
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_killed       = killed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a small in-order icache model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_pc;
  logic [31:0] f_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_killed;
`endif

  always #5 clk = ~clk;

  fetch_if icache ();

  fetch_stage #(
    .RESET_PC       (32'h0000_2000),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .icache           (icache.master),
    .f_valid          (f_valid),
    .f_ready          (f_ready),
    .f_pc             (f_pc),
    .f_inst           (f_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_killed      (perf_killed)
`endif
  );

  int           compared   = 0;
  int           mismatched = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  pend_q[$];
  bit           cache_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back('{pc: pc, inst: inst});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Cache model: records handshakes, answers in order one cycle later with addr ^ 0xDEAD0000.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_q.delete();
    end else if (icache.req_valid && icache.req_ready) begin
      pend_q.push_back(icache.req_addr);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset_n || cache_hold || (pend_q.size() == 0)) begin
      icache.resp_valid = 1'b0;
      icache.resp_data  = 32'h0;
    end else begin
      icache.resp_data  = pend_q.pop_front() ^ 32'hDEAD_0000;
      icache.resp_valid = 1'b1;
    end
  end

  // Monitor: every instruction decode accepts must be the next expected one.
  always @(negedge clk) begin
    if (reset_n && f_valid && f_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_inst: got pc %h inst %h, expected none", f_pc, f_inst);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("f_pc", f_pc, e.pc);
        chk("f_inst", f_inst, e.inst);
      end
    end
  end

  initial begin
    reset_n           = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    f_ready           = 1'b1;
    icache.req_ready  = 1'b1;
    icache.resp_valid = 1'b0;
    icache.resp_data  = 32'h0;

    next_cycle();
    next_cycle();
    #1;
    chk("rst_req_valid", 32'(icache.req_valid), 32'd0);
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_f_pc", f_pc, 32'h0);
    chk("rst_f_inst", f_inst, 32'h0000_0013);
`ifdef FETCH_PERF_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_killed", perf_killed, 32'd0);
`endif

    // Cycle 0 (boot)
    reset_n = 1'b1;
    expect_inst(32'h2000, 32'hDEAD_2000);
    expect_inst(32'h2004, 32'hDEAD_2004);
    #1;
    chk("boot_no_req", 32'(icache.req_valid), 32'd0);
    next_cycle(); #1;  // c1
    chk("c1_req_valid", 32'(icache.req_valid), 32'd1);
    chk("c1_req_addr", icache.req_addr, 32'h2000);
    next_cycle(); #1;  // c2
    chk("c2_no_f_valid", 32'(f_valid), 32'd0);

    // c3..c5: cache refuses requests; address must hold at 0x2008
    next_cycle();
    icache.req_ready = 1'b0;
    expect_inst(32'h2008, 32'hDEAD_2008);
    expect_inst(32'h200C, 32'hDEAD_200C);
    expect_inst(32'h2010, 32'hDEAD_2010);
    #1;
    chk("c3_first_f_valid", 32'(f_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        next_cycle(); #1;
      end
      chk("ready_stall_req_valid", 32'(icache.req_valid), 32'd1);
      chk("ready_stall_addr", icache.req_addr, 32'h2008);
    end
    chk("c5_buf_empty", 32'(f_valid), 32'd0);
    next_cycle();  // c6
    icache.req_ready = 1'b1;
    #1;
    chk("c6_addr", icache.req_addr, 32'h2008);
    next_cycle();  // c7
    next_cycle();  // c8

    // c9..c13: decode stalls, buffer fills, requests stop
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      f_ready = 1'b0;
      #1;
      chk("stall_req_off", 32'(icache.req_valid), 32'd0);
      chk("stall_f_pc", f_pc, 32'h200C);
      chk("stall_f_inst", f_inst, 32'hDEAD_200C);
    end
    next_cycle();  // c14
    f_ready = 1'b1;
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_stall_5", perf_stall_cycles, 32'd5);
`endif
    next_cycle();  // c15
    next_cycle();  // c16
    f_ready = 1'b0;

    // c17: redirect with full buffer and f_ready high
    next_cycle();
    f_ready        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3003;
    expect_inst(32'h3000, 32'hDEAD_3000);
    expect_inst(32'h3004, 32'hDEAD_3004);
    #1;
    chk("redir_f_valid_masked", 32'(f_valid), 32'd0);
    chk("redir_no_req", 32'(icache.req_valid), 32'd0);
    next_cycle();  // c18
    redirect_valid = 1'b0;
    #1;
    chk("redir_target_req", 32'(icache.req_valid), 32'd1);
    chk("redir_target_addr", icache.req_addr, 32'h3000);
    chk("redir_buf_flushed", 32'(f_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_killed_flush", perf_killed, 32'd2);
`endif
    next_cycle();  // c19
    next_cycle();  // c20
    #1;
    cache_hold = 1'b1;
    next_cycle();  // c21

    // c22: redirect with two requests in flight and an empty buffer
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    expect_inst(32'h4000, 32'hDEAD_4000);
    expect_inst(32'h4004, 32'hDEAD_4004);
    #1;
    chk("redir2_no_req", 32'(icache.req_valid), 32'd0);
    chk("redir2_f_valid", 32'(f_valid), 32'd0);
    cache_hold = 1'b0;
    next_cycle();  // c23
    redirect_valid = 1'b0;
    #1;
    chk("drain_no_credit", 32'(icache.req_valid), 32'd0);
    next_cycle(); #1;  // c24
    chk("redir2_req", 32'(icache.req_valid), 32'd1);
    chk("redir2_addr", icache.req_addr, 32'h4000);
    next_cycle();  // c25
    next_cycle();  // c26
    #1;
`ifdef FETCH_PERF_EN
    chk("perf_killed_stale", perf_killed, 32'd4);
`endif
    next_cycle();  // c27

    // c28: reset mid-stream
    next_cycle();
    reset_n = 1'b0;
    #1;
    chk("midrst_f_valid", 32'(f_valid), 32'd0);
    chk("midrst_req_valid", 32'(icache.req_valid), 32'd0);
    chk("midrst_f_pc", f_pc, 32'h0);
    chk("midrst_f_inst", f_inst, 32'h0000_0013);
`ifdef FETCH_PERF_EN
    chk("midrst_perf_stall", perf_stall_cycles, 32'd0);
    chk("midrst_perf_killed", perf_killed, 32'd0);
`endif
    next_cycle();  // c29
    next_cycle();  // c30 = new cycle 0
    reset_n = 1'b1;
    expect_inst(32'h2000, 32'hDEAD_2000);
    expect_inst(32'h2004, 32'hDEAD_2004);
    #1;
    chk("reboot_no_req", 32'(icache.req_valid), 32'd0);
    next_cycle(); #1;  // c31
    chk("reboot_req_valid", 32'(icache.req_valid), 32'd1);
    chk("reboot_addr", icache.req_addr, 32'h2000);
    next_cycle();  // c32
    next_cycle(); #1;  // c33
    chk("reboot_f_valid", 32'(f_valid), 32'd1);
    chk("reboot_f_pc", f_pc, 32'h2000);
    next_cycle();  // c34
    next_cycle();  // c35
    f_ready = 1'b0;
    next_cycle();
    next_cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
